updown_bcd_display: RTL
=======================

# updown_bcd_display

Parametrised reversible BCD counter with a multiplexed N-digit seven-segment driver, clocked from the board 50 MHz clock. It generalises the fixed 4-digit reversible counter top to the following:
- configurable digit count, count rate and scan rate;
- synchronous load and count enable;
- wrap detection;
- optional leading-zero blanking.

It sits directly between the board pins (SEL/SEG) and user switches, and exposes the raw BCD count for other blocks.

## Interface
- DIGITS, 4: number of BCD decades and display digits (1–8)
- CLK_HZ, 50_000_000: CLK_50 frequency in Hz
- COUNT_HZ, 1: count-tick rate; tick period TDIV = CLK_HZ/COUNT_HZ cycles (integer, ≥2)
- SCAN_DIV, 12_500: CLK_50 cycles each digit is shown (≥1)
- BLANK_LZ, 0: 1 = blank leading zero digits (digit 0 is never blanked)

Ports:
- CLK_50  in  1  system clock
- CLR  in  1  synchronous reset, active-high
- revert  in  1  direction; 0 = up, 1 = down
- EN  in  1  count enable; 0 freezes prescaler and count
- LOAD  in  1  synchronous load strobe
- LOAD_VAL  in  4*DIGITS  BCD value, digit 0 in [3:0]
- COUNT  out  4*DIGITS  current BCD count, registered
- WRAP  out  1  one-cycle pulse on roll-over (all-9s↔0)
- SEL  out  DIGITS  digit select, one-hot active-low
- SEG  out  7  segments active-low, SEG[0]=a … SEG[6]=g

## Operation
- Priority per edge: CLR > LOAD > tick count.
- **CLR**: COUNT=0, prescaler=0, scan index=0, WRAP=0, SEL=~1 (digit 0 on), SEG=7'b1000000 ("0").
- **LOAD**:
  - COUNT ← LOAD_VAL, prescaler ← 0, WRAP=0.
  - Any LOAD_VAL nibble >9 loads as 0 for that digit only.
  - LOAD is honoured regardless of EN.
- **Prescaler**: counts 0..TDIV-1 while EN=1. A tick fires on the edge where the prescaler wraps. EN=0 holds the prescaler value.
- **Tick, revert=0**: BCD increment with decimal carry across decades. All-9s → 0 and WRAP=1 on that same edge.
- **Tick, revert=1**: BCD decrement with borrow. 0 → all-9s and WRAP=1.
- **revert**: sampled only at the tick edge. A change mid-period does not reset the prescaler.
- **Scan**:
  - Index 0..DIGITS-1 advances every SCAN_DIV cycles and wraps to 0.
  - Scanning runs independently of EN and LOAD, and is reset only by CLR.
- **Decode**:
  - Standard 0–9 patterns.
  - A blanked digit drives SEG=7'b1111111 with SEL still active.
  - BLANK_LZ blanks digit i>0 when digit i and all higher digits are 0.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- **COUNT/WRAP**: updated on the tick or LOAD edge, visible the cycle after.
- **WRAP**: high for exactly one cycle and never asserted by LOAD or CLR.
- **SEL/SEG**:
  - Reflect the scan index and COUNT with one cycle latency. A COUNT change appears on SEG on the next cycle the affected digit is selected.
  - SEL and SEG change on the same edge; no overlap cycle.
- **Simultaneous LOAD and tick**: LOAD wins. The tick is discarded and no WRAP is raised.
- **CLR mid-period**: the partial prescaler count is lost; the first tick after CLR arrives TDIV cycles after CLR deasserts (with EN=1).
- **DIGITS=1**: SEL is a constant 0 (active).

## Structure
- Package updown_bcd_pkg:
  - BCD digit typedef (4 bits);
  - 7-bit segment typedef;
  - constants SEG_BLANK and SEG_ZERO;
  - a seg7 decode function;
  - a clog2-based width helper for the prescaler and scan counters.
- Sub-module bcd_digit_cell: one decade.
  - Inputs: tick, dir, cin/bin (carry or borrow in).
  - Outputs: digit, cout/bout (carry or borrow out), flagging 9→0 going up or 0→9 going down.
  - Instantiated DIGITS times in a generate chain.
- Top level contains the prescaler, load logic, WRAP (AND of the chain-end carry/borrow with tick), scan counter and output registers.

## Test plan
Bench uses CLK_HZ=1000, COUNT_HZ=100 (TDIV=10), SCAN_DIV=2, DIGITS=4.
- **Reset and count up**: CLR for 2 cycles, EN=1, revert=0 → COUNT=16'h0000 after reset. COUNT=16'h0001 10 cycles after CLR falls, then 16'h0010 after 10 ticks.
- **Up wrap**: LOAD 16'h9998, count up → sequence 9999 then 0000. WRAP high exactly 1 cycle, aligned with the 0000 update.
- **Down wrap and invalid load**:
  - LOAD 16'h0001 with revert=1 → 0000 then 9999, with a WRAP pulse.
  - LOAD 16'h00A5 → COUNT=16'h0005.
- **Hold and priority**:
  - EN=0 for 50 cycles → COUNT unchanged, scan still cycles SEL 1110→1101→1011→0111 every 2 cycles.
  - LOAD asserted on a tick edge → COUNT=LOAD_VAL, no increment.
- **Display decode**:
  - COUNT=16'h0042, BLANK_LZ=1 → digit 3 and digit 2 SEG=7'b1111111; digit 1 = "4" (7'b0011001); digit 0 = "2" (7'b0100100).
  - With BLANK_LZ=0, digits 3 and 2 show "0".
- **CLR mid-operation**: CLR at prescaler=7 during a count → next-cycle COUNT=0, SEL=4'b1110, SEG=7'b1000000. First tick occurs 10 cycles after CLR deasserts.

Source files
------------

// File: rtl/updown_bcd_pkg.sv
// Shared types, segment constants and helpers for the reversible BCD counter/display.
package updown_bcd_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Active-low segments, bit 0 = a ... bit 6 = g
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_ZERO  = 7'b1000000;

  function automatic seg_t seg7(input bcd_t d);
    seg_t s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Bits needed to hold 0..n-1, never less than one
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: loadable, counts up or down when tick and carry/borrow-in are both set.
module bcd_digit_cell
  import updown_bcd_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  input  logic tick,
  input  logic dir,
  input  logic cin,
  output bcd_t digit,
  output logic cout
);

  bcd_t digit_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      digit_q <= '0;
    end else if (load) begin
      digit_q <= (load_val > 4'd9) ? 4'd0 : load_val;
    end else if (tick && cin) begin
      if (dir) digit_q <= (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
      else     digit_q <= (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  assign digit = digit_q;
  assign cout  = cin && (dir ? (digit_q == 4'd0) : (digit_q == 4'd9));

endmodule

// File: rtl/updown_bcd_display.sv
// Reversible N-digit BCD counter with prescaler, wrap pulse and multiplexed seven-segment drive.
module updown_bcd_display
  import updown_bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned COUNT_HZ = 1,
  parameter int unsigned SCAN_DIV = 12_500,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic                  CLK_50,
  input  logic                  CLR,
  input  logic                  revert,
  input  logic                  EN,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  WRAP,
  output logic [DIGITS-1:0]     SEL,
  output logic [6:0]            SEG
);

  localparam int unsigned TDIV = CLK_HZ / COUNT_HZ;
  localparam int unsigned PW   = cnt_width(TDIV);
  localparam int unsigned SW   = cnt_width(SCAN_DIV);
  localparam int unsigned IW   = cnt_width(DIGITS);

  logic [PW-1:0]     presc_q;
  logic              tick;
  logic [DIGITS:0]   carry;
  bcd_t              digit [DIGITS];
  logic              wrap_q;
  logic [SW-1:0]     scan_q;
  logic [IW-1:0]     idx_q;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] sel_q;
  seg_t              seg_q;

  assign tick = EN && (presc_q == PW'(TDIV - 1));

  always_ff @(posedge CLK_50) begin
    if (CLR || LOAD)  presc_q <= '0;
    else if (tick)    presc_q <= '0;
    else if (EN)      presc_q <= presc_q + 1'b1;
  end

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_digit_cell u_cell (
      .clk      (CLK_50),
      .clr      (CLR),
      .load     (LOAD),
      .load_val (LOAD_VAL[4*g +: 4]),
      .tick     (tick),
      .dir      (revert),
      .cin      (carry[g]),
      .digit    (digit[g]),
      .cout     (carry[g+1])
    );
  end

  always_comb begin
    COUNT = '0;
    for (int i = 0; i < DIGITS; i++) COUNT[4*i +: 4] = digit[i];
  end

  // LOAD discards a coincident tick, so it must also suppress the wrap pulse
  always_ff @(posedge CLK_50) begin
    if (CLR || LOAD) wrap_q <= 1'b0;
    else             wrap_q <= tick && carry[DIGITS];
  end

  always_ff @(posedge CLK_50) begin
    if (CLR) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  // A digit is a leading zero when it and every higher digit are zero
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run      = run && (digit[i] == 4'd0);
      blank[i] = BLANK_LZ && (i != 0) && run;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (CLR) begin
      sel_q <= ~DIGITS'(1);
      seg_q <= SEG_ZERO;
    end else begin
      sel_q <= ~(DIGITS'(1) << idx_q);
      seg_q <= blank[idx_q] ? SEG_BLANK : seg7(digit[idx_q]);
    end
  end

  assign WRAP = wrap_q;
  assign SEL  = sel_q;
  assign SEG  = seg_q;

endmodule
